mem_arbiter: RTL and testbench

Shares the single-port unified instruction/data memory between two requesters.
- Master 0 is the multicycle core's memory port (FETCH/MEMREAD/MEMWRITE accesses).
- Master 1 is the program loader/debug port.
- Grants one access at a time with 2-way round-robin, sequences the fixed memory latency, and returns read data with a one-cycle valid pulse so the core can stall.
- Sits between the core/loader and the memory macro.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_rr.sv | 29 ++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  localparam int STALL_CNT_W = 16;

  // Wide enough to hold MEM_LAT itself; never narrower than one bit.
  function automatic int lat_cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_rr
// Description : Combinational two-way round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       winner_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = M_CPU;
    unique case (req_i)
      2'b01:   winner_o = M_CPU;
      2'b10:   winner_o = M_LDR;
      // On a tie the master that did not win last time gets the slot.
      2'b11:   winner_o = ~last_gnt_i;
      default: winner_o = M_CPU;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing a fixed-latency single-port
//               memory between the core (m0) and the loader/debug port (m1).
//               Define MEM_ARB_PERF_EN to add per-master stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [STALL_CNT_W-1:0] stall_cnt_m0,
  output logic [STALL_CNT_W-1:0] stall_cnt_m1,
`endif
  output logic                busy
);

  localparam int CNT_W = lat_cnt_w(MEM_LAT);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  arb_state_e         state_q;
  logic               owner_q;
  logic               last_gnt_q;
  logic               is_read_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               m0_rvalid_q;
  logic               m1_rvalid_q;
  logic [DATA_W-1:0]  m0_rdata_q;
  logic [DATA_W-1:0]  m1_rdata_q;

  logic               w_winner;
  logic               w_valid;
  logic               w_issue;

  mem_arb_rr u_rr (
    .req_i      ({m1_req, m0_req}),
    .last_gnt_i (last_gnt_q),
    .winner_o   (w_winner),
    .valid_o    (w_valid)
  );

  // Reset gates the issue path so nothing leaks onto the memory bus while held.
  always_comb begin
    w_issue   = (state_q == IDLE) && !reset && w_valid;
    m0_gnt    = w_issue && (w_winner == M_CPU);
    m1_gnt    = w_issue && (w_winner == M_LDR);
    mem_en    = w_issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (w_issue) begin
      if (w_winner == M_LDR) begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_be    = m1_be;
      end else begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_be    = m0_be;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= M_CPU;
      last_gnt_q  <= M_LDR;
      is_read_q   <= 1'b0;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (w_issue) begin
            state_q    <= WAIT;
            owner_q    <= w_winner;
            last_gnt_q <= w_winner;
            is_read_q  <= ~mem_we;
            cnt_q      <= CNT_W'(MEM_LAT);
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (is_read_q) begin
              if (owner_q == M_LDR) m1_rdata_q <= mem_rdata;
              else                  m0_rdata_q <= mem_rdata;
            end
            if (owner_q == M_LDR) m1_rvalid_q <= 1'b1;
            else                  m0_rvalid_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = (state_q != IDLE);

`ifdef MEM_ARB_PERF_EN
  logic [STALL_CNT_W-1:0] stall_m0_q;
  logic [STALL_CNT_W-1:0] stall_m1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_m0_q <= '0;
      stall_m1_q <= '0;
    end else begin
      if (m0_req && !m0_gnt && (stall_m0_q != '1)) stall_m0_q <= stall_m0_q + 1'b1;
      if (m1_req && !m1_gnt && (stall_m1_q != '1)) stall_m1_q <= stall_m1_q + 1'b1;
    end
  end

  assign stall_cnt_m0 = stall_m0_q;
  assign stall_cnt_m1 = stall_m1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (MEM_LAT=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic [BE_W-1:0]   m0_be;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [BE_W-1:0]   m1_be;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [BE_W-1:0]   mem_be;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]       stall_cnt_m0, stall_cnt_m1;
`endif

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_PERF_EN
    .stall_cnt_m0(stall_cnt_m0), .stall_cnt_m1(stall_cnt_m1),
`endif
    .busy(busy)
  );

`ifdef MEM_ARB_PERF_EN
  // Long-latency instance used only to drive a stall counter into saturation.
  logic              s_reset, s_m0_req, s_m1_req;
  logic              s_m0_gnt, s_m0_rvalid, s_m1_gnt, s_m1_rvalid;
  logic [DATA_W-1:0] s_m0_rdata, s_m1_rdata, s_mem_wdata;
  logic              s_mem_en, s_mem_we, s_busy;
  logic [ADDR_W-1:0] s_mem_addr;
  logic [BE_W-1:0]   s_mem_be;
  logic [15:0]       s_stall_m0, s_stall_m1;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(70000)) u_dut_sat (
    .clk(clk), .reset(s_reset),
    .m0_req(s_m0_req), .m0_we(1'b0), .m0_addr('0), .m0_wdata('0), .m0_be('0),
    .m0_gnt(s_m0_gnt), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata),
    .m1_req(s_m1_req), .m1_we(1'b0), .m1_addr('0), .m1_wdata('0), .m1_be('0),
    .m1_gnt(s_m1_gnt), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_be(s_mem_be), .mem_rdata(mem_rdata),
    .stall_cnt_m0(s_stall_m0), .stall_cnt_m1(s_stall_m1),
    .busy(s_busy)
  );
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = '0; m0_be = 4'hF;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0;     m1_wdata = '0; m1_be = '0;
    mem_rdata = 32'h0;
`ifdef MEM_ARB_PERF_EN
    s_reset = 1'b1; s_m0_req = 1'b0; s_m1_req = 1'b0;
`endif

    // Reset held three cycles with m0 requesting
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
    end

    // CPU read, cycle T
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rd_m0_gnt_T", m0_gnt, 1);
    chk("rd_mem_en_T", mem_en, 1);
    chk("rd_mem_we_T", mem_we, 0);
    chk("rd_mem_addr_T", mem_addr, 32'h100);
    chk("rd_m1_gnt_T", m1_gnt, 0);
    tick(); m0_req = 1'b0; m0_addr = 32'h0;
    @(negedge clk);
    chk("rd_busy_T1", busy, 1);
    chk("rd_mem_en_T1", mem_en, 0);
    tick(); mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_rvalid_T2", m0_rvalid, 0);
    tick(); mem_rdata = 32'h0;
    @(negedge clk);
    chk("rd_rvalid_T3", m0_rvalid, 1);
    chk("rd_rdata_T3", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid_T3", m1_rvalid, 0);
    chk("rd_m1_rdata_T3", m1_rdata, 0);
    tick();
    @(negedge clk);
    chk("rd_rvalid_T4", m0_rvalid, 0);
    chk("rd_busy_T4", busy, 0);
    chk("rd_rdata_hold_T4", m0_rdata, 32'hDEADBEEF);

    // Contention from reset release: grants every MEM_LAT+2 cycles, alternating
    tick(); reset = 1'b1; m0_req = 1'b1; m1_req = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    tick(); reset = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      chk($sformatf("cont_m0_gnt_%0d", k), m0_gnt, (k == 0 || k == 8));
      chk($sformatf("cont_m1_gnt_%0d", k), m1_gnt, (k == 4));
      chk($sformatf("cont_m0_rvalid_%0d", k), m0_rvalid, (k == 3));
      chk($sformatf("cont_m1_rvalid_%0d", k), m1_rvalid, (k == 7));
    end
    tick(); m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tick();
    tick();
    chk("cont_m1_rdata", m1_rdata, 32'hCAFE0001);

    // Loader write, cycle W; m0 request arrives while busy
    mem_rdata = 32'hBAD0BAD0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h12345678; m1_be = 4'b0011;
    @(negedge clk);
    chk("wr_m1_gnt_W", m1_gnt, 1);
    chk("wr_mem_en_W", mem_en, 1);
    chk("wr_mem_we_W", mem_we, 1);
    chk("wr_mem_be_W", mem_be, 4'b0011);
    chk("wr_mem_addr_W", mem_addr, 32'h40);
    chk("wr_mem_wdata_W", mem_wdata, 32'h12345678);
    chk("wr_m0_gnt_W", m0_gnt, 0);
    tick();
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
    @(negedge clk);
    chk("wr_mem_we_W1", mem_we, 0);
    chk("wr_mem_be_W1", mem_be, 0);
    chk("wr_mem_en_W1", mem_en, 0);
    chk("holdoff_m0_gnt_W1", m0_gnt, 0);
    tick();
    @(negedge clk);
    chk("holdoff_m0_gnt_W2", m0_gnt, 0);
    chk("wr_m1_rvalid_W2", m1_rvalid, 0);
    tick();
    @(negedge clk);
    chk("wr_m1_rvalid_W3", m1_rvalid, 1);
    chk("wr_m1_rdata_W3", m1_rdata, 32'hCAFE0001);
    chk("holdoff_m0_gnt_W3", m0_gnt, 0);
    chk("wr_m0_rvalid_W3", m0_rvalid, 0);
    tick();
    @(negedge clk);
    chk("wr_m1_rvalid_W4", m1_rvalid, 0);
    chk("next_m0_gnt_W4", m0_gnt, 1);
    chk("next_mem_addr_W4", mem_addr, 32'h200);

    // Reset while the m0 read is in WAIT
    tick(); m0_req = 1'b0; m0_addr = '0;
    @(negedge clk);
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_busy_reset", busy, 0);
    tick(); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid_no_m0_rvalid_%0d", k), m0_rvalid, 0);
      chk($sformatf("mid_no_m1_rvalid_%0d", k), m1_rvalid, 0);
      tick();
    end
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    chk("mid_tie_m0_gnt", m0_gnt, 1);
    chk("mid_tie_m1_gnt", m1_gnt, 0);
    tick(); m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) tick();

`ifdef MEM_ARB_PERF_EN
    // m1 blocked three cycles behind an m0 access
    reset = 1'b1;
    tick(); reset = 1'b0; m0_req = 1'b1;
    @(negedge clk);
    chk("perf_m0_gnt", m0_gnt, 1);
    tick(); m0_req = 1'b0; m1_req = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("perf_m1_gnt", m1_gnt, 1);
    chk("perf_stall_m1", stall_cnt_m1, 16'd3);
    chk("perf_stall_m0", stall_cnt_m0, 16'd0);
    tick(); m1_req = 1'b0;

    // Saturation: m1 held off for 70000 cycles behind a very long access
    s_reset = 1'b0; s_m0_req = 1'b1; s_m1_req = 1'b1;
    @(negedge clk);
    chk("sat_m0_gnt", s_m0_gnt, 1);
    tick(); s_m0_req = 1'b0;
    repeat (70000) tick();
    @(negedge clk);
    chk("sat_m1_gnt", s_m1_gnt, 0);
    chk("sat_stall_m1", s_stall_m1, 16'hFFFF);
    chk("sat_stall_m0", s_stall_m0, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
